idelay_sweep_controller: RTL and testbench

Sequencer for the ISERDES/IDELAY histogram datapath. Steps the IDELAY tap through every setting, lets the delay settle, then gates the error counter for a fixed dwell window at each tap. It latches the per-tap error count and hands `(tap, errors)` records to the message formatter over a valid/ready handshake. It also tracks the tap with the fewest errors for the calibrator.

---
 rtl/idelay_sweep_pkg.sv | 27 ++
 rtl/idelay_sweep_controller_timer.sv | 35 +++
 rtl/idelay_sweep_controller.sv | 184 ++++++++++++++++++
 tb/tb_idelay_sweep_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idelay_sweep_pkg.sv
// Shared definitions for the IDELAY histogram datapath: sweep defaults and
// sequencer state encodings.
package idelay_sweep_pkg;

  localparam int TAPS_DEF    = 32;
  localparam int TAP_W_DEF   = 5;
  localparam int COUNT_W_DEF = 24;
  localparam int DWELL_DEF   = 4096;
  localparam int SETTLE_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_LOAD     = 3'd2,
    S_SETTLE   = 3'd3,
    S_COUNT    = 3'd4,
    S_LATCH    = 3'd5,
    S_EMIT     = 3'd6,
    S_DONE     = 3'd7
  } sweep_state_e;

  // One spare bit so a loaded phase length never aliases to zero.
  function automatic int timer_width(input int dwell, input int settle);
    return $clog2((dwell > settle) ? dwell : settle) + 1;
  endfunction

endpackage

// File: rtl/idelay_sweep_controller_timer.sv
// Loadable down-counter shared by the SETTLE and COUNT phases; zero_o flags
// the final cycle of the loaded interval.
module sweep_timer #(
  parameter int W = 13
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/idelay_sweep_controller.sv
// Steps the IDELAY tap through every setting, gates the error counter for a
// dwell window per tap, and streams (tap, errors) records out while tracking the best tap.
module idelay_sweep_controller
  import idelay_sweep_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int TAP_W   = TAP_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int DWELL   = DWELL_DEF,
  parameter int SETTLE  = SETTLE_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  input  logic               DLY_RDY,
  output logic               DLY_LD,
  output logic [TAP_W-1:0]   DLY_TAP,
  output logic               CNT_RST,
  output logic               CNT_EN,
  input  logic [COUNT_W-1:0] ERR_COUNT,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [TAP_W-1:0]   OUT_TAP,
  output logic [COUNT_W-1:0] OUT_ERR,
  output logic [TAP_W-1:0]   BEST_TAP,
  output logic [COUNT_W-1:0] BEST_ERR,
  output logic [2:0]         DBG_STATE
);

  // Handshake: a record transfers on every rising CLK where OUT_VALID and
  // OUT_READY are both high; OUT_VALID/OUT_TAP/OUT_ERR hold until then.

  localparam int                 TIMER_W   = timer_width(DWELL, SETTLE);
  localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE - 1);
  localparam logic [TIMER_W-1:0] DWELL_LD  = TIMER_W'(DWELL - 1);
  localparam logic [TAP_W:0]     LAST_TAP  = (TAP_W + 1)'(TAPS - 1);

  sweep_state_e       state_q, state_d;
  logic [TAP_W:0]     tap_q, tap_d;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;
  logic               accept;

  logic               busy_q, done_q, dly_ld_q, cnt_rst_q, cnt_en_q, out_valid_q;
  logic [TAP_W-1:0]   dly_tap_q, out_tap_q, best_tap_q, work_tap_q;
  logic [COUNT_W-1:0] out_err_q, best_err_q, work_err_q;

  sweep_timer #(.W(TIMER_W)) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign accept = (state_q == S_EMIT) && OUT_READY;

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = SETTLE_LD;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          tap_d   = '0;
          state_d = DLY_RDY ? S_LOAD : S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (DLY_RDY) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!DLY_RDY) begin
          state_d = S_WAIT_RDY;
        end else begin
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (!DLY_RDY) begin
          state_d = S_WAIT_RDY;
        end else if (tmr_zero) begin
          state_d  = S_COUNT;
          tmr_load = 1'b1;
          tmr_val  = DWELL_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_COUNT: begin
        if (!DLY_RDY) begin
          state_d = S_WAIT_RDY;
        end else if (tmr_zero) begin
          state_d = S_LATCH;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_LATCH: begin
        state_d = DLY_RDY ? S_EMIT : S_WAIT_RDY;
      end
      S_EMIT: begin
        // Losing DLY_RDY here only delays the next tap; this record completes.
        if (OUT_READY) begin
          if (tap_q == LAST_TAP) begin
            state_d = S_DONE;
          end else begin
            tap_d   = tap_q + 1'b1;
            state_d = DLY_RDY ? S_LOAD : S_WAIT_RDY;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dly_ld_q    <= 1'b0;
      cnt_rst_q   <= 1'b0;
      cnt_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dly_tap_q   <= '0;
      out_tap_q   <= '0;
      out_err_q   <= '0;
      work_tap_q  <= '0;
      work_err_q  <= '1;
      best_tap_q  <= '0;
      best_err_q  <= '1;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      dly_ld_q    <= (state_d == S_LOAD);
      cnt_rst_q   <= (state_d == S_LOAD) || (state_d == S_SETTLE);
      cnt_en_q    <= (state_d == S_COUNT);
      out_valid_q <= (state_d == S_EMIT);
      if (state_d == S_LOAD) dly_tap_q <= tap_d[TAP_W-1:0];
      if ((state_q == S_LATCH) && (state_d == S_EMIT)) begin
        out_tap_q <= tap_q[TAP_W-1:0];
        out_err_q <= ERR_COUNT;
      end
      // Strict compare with taps visited in ascending order: ties keep the lower tap.
      if (state_q == S_IDLE) begin
        work_tap_q <= '0;
        work_err_q <= '1;
      end else if (accept && (out_err_q < work_err_q)) begin
        work_tap_q <= out_tap_q;
        work_err_q <= out_err_q;
      end
      if (state_q == S_DONE) begin
        best_tap_q <= work_tap_q;
        best_err_q <= work_err_q;
      end
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DLY_LD    = dly_ld_q;
  assign DLY_TAP   = dly_tap_q;
  assign CNT_RST   = cnt_rst_q;
  assign CNT_EN    = cnt_en_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_TAP   = out_tap_q;
  assign OUT_ERR   = out_err_q;
  assign BEST_TAP  = best_tap_q;
  assign BEST_ERR  = best_err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_idelay_sweep_controller.sv
// Scoreboard bench for idelay_sweep_controller with a small error-counter model
// whose count depends on how many CNT_EN cycles each tap actually received.
module tb_idelay_sweep_controller;

  localparam int TAPS    = 4;
  localparam int TAP_W   = 5;
  localparam int COUNT_W = 24;
  localparam int DWELL   = 16;
  localparam int SETTLE  = 2;
  localparam int REC_W   = TAP_W + COUNT_W;
  localparam int TAP_CYC = SETTLE + DWELL + 3;

  logic               CLK = 1'b0;
  logic               RST, START, DLY_RDY, OUT_READY;
  logic               BUSY, DONE, DLY_LD, CNT_RST, CNT_EN, OUT_VALID;
  logic [TAP_W-1:0]   DLY_TAP, OUT_TAP, BEST_TAP;
  logic [COUNT_W-1:0] ERR_COUNT, OUT_ERR, BEST_ERR;
  logic [2:0]         DBG_STATE;

  idelay_sweep_controller #(
    .TAPS(TAPS), .TAP_W(TAP_W), .COUNT_W(COUNT_W), .DWELL(DWELL), .SETTLE(SETTLE)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
    .DLY_RDY(DLY_RDY), .DLY_LD(DLY_LD), .DLY_TAP(DLY_TAP),
    .CNT_RST(CNT_RST), .CNT_EN(CNT_EN), .ERR_COUNT(ERR_COUNT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_TAP(OUT_TAP), .OUT_ERR(OUT_ERR),
    .BEST_TAP(BEST_TAP), .BEST_ERR(BEST_ERR), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- error counter model ----------------
  // Errors arrive in the last err_tab[tap] enable cycles, so a short dwell undercounts.
  logic [COUNT_W-1:0] err_tab [TAPS];
  int                 en_run = 0;
  logic [COUNT_W-1:0] err_cnt = '0;

  always @(posedge CLK) begin
    if (CNT_RST) begin
      en_run  <= 0;
      err_cnt <= '0;
    end else if (CNT_EN) begin
      en_run <= en_run + 1;
      if (en_run >= DWELL - int'(err_tab[DLY_TAP])) err_cnt <= err_cnt + 1'b1;
    end
  end
  assign ERR_COUNT = err_cnt;

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0]   exp_q[$];
  logic [TAP_W-1:0]   exp_best_tap;
  logic [COUNT_W-1:0] exp_best_err;
  int                 rec_cnt = 0;
  int                 done_cnt = 0;
  bit                 spacing_chk = 0;
  bit                 have_ld = 0;
  int                 last_ld = 0;
  int                 ld0 = 0;
  bit                 ld_next = 0, done_next = 0, best_next = 0, hold_next = 0, prev_valid = 0;
  logic [TAP_W-1:0]   hold_tap;
  logic [COUNT_W-1:0] hold_err;
  logic [REC_W-1:0]   exp_rec;

  always @(negedge CLK) begin
    if (RST) begin
      if (ld_next) check("ld_after_accept", DLY_LD, 1);
      if (done_next) check("done_after_last", DONE, 1);
      if (best_next) begin
        check("best_tap", BEST_TAP, exp_best_tap);
        check("best_err", BEST_ERR, exp_best_err);
      end
      if (hold_next) begin
        check("hold_valid", OUT_VALID, 1);
        check("hold_tap", OUT_TAP, hold_tap);
        check("hold_err", OUT_ERR, hold_err);
      end
      ld_next = 0; done_next = 0; best_next = 0; hold_next = 0;

      if (OUT_VALID && !prev_valid) check("dwell_len", en_run, DWELL);
      if (OUT_VALID && OUT_READY) begin
        rec_cnt++;
        if (exp_q.size() == 0) begin
          check("rec_unexpected", exp_q.size(), 1);
        end else begin
          exp_rec = exp_q.pop_front();
          check("record", {OUT_TAP, OUT_ERR}, exp_rec);
        end
        if (OUT_TAP == TAP_W'(TAPS - 1)) done_next = 1;
        else if (DLY_RDY) ld_next = 1;
      end
      if (OUT_VALID && !OUT_READY) begin
        hold_next = 1;
        hold_tap  = OUT_TAP;
        hold_err  = OUT_ERR;
      end
      if (DLY_LD) begin
        if (spacing_chk && have_ld) check("ld_spacing", cyc - last_ld, TAP_CYC);
        if (!have_ld) ld0 = cyc;
        have_ld = 1;
        last_ld = cyc;
      end
      if (DONE) begin
        done_cnt++;
        best_next = 1;
        check("queue_empty", exp_q.size(), 0);
        check("rec_count", rec_cnt, TAPS);
        if (spacing_chk) check("sweep_len", cyc - ld0 + 1, TAPS * TAP_CYC + 1);
      end
      prev_valid = OUT_VALID;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_sweep();
    exp_best_tap = '0;
    exp_best_err = '1;
    for (int i = 0; i < TAPS; i++) begin
      exp_q.push_back({TAP_W'(i), err_tab[i]});
      if (err_tab[i] < exp_best_err) begin
        exp_best_err = err_tab[i];
        exp_best_tap = TAP_W'(i);
      end
    end
    rec_cnt = 0;
    have_ld = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_to_ld", DLY_LD, 1);
    check("start_tap0", DLY_TAP, 0);
  endtask

  task automatic rand_errs();
    for (int i = 0; i < TAPS; i++) err_tab[i] = COUNT_W'($urandom_range(0, DWELL));
  endtask

  task automatic wait_done(input int budget);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != start_cnt) return;
    end
    check("done_timeout", done_cnt, start_cnt + 1);
  endtask

  task automatic wait_ld_tap(input int tap, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (DLY_LD && (DLY_TAP == TAP_W'(tap))) return;
    end
    check("ld_timeout", DLY_TAP, tap);
  endtask

  // ---------------- test sequence ----------------
  int d0;

  initial begin
    RST = 1'b0; START = 1'b0; DLY_RDY = 1'b1; OUT_READY = 1'b1;
    for (int i = 0; i < TAPS; i++) err_tab[i] = '0;
    repeat (3) tick();
    check("rst_ctrl", {BUSY, DONE, DLY_LD, CNT_RST, CNT_EN, OUT_VALID}, 0);
    check("rst_best_err", BEST_ERR, 24'hFFFFFF);
    check("rst_state", DBG_STATE, 0);
    RST = 1'b1;
    tick();

    // Basic sweep with cycle-accurate spacing checks.
    spacing_chk = 1;
    rand_errs();
    start_sweep();
    check("busy_in_sweep", BUSY, 1);
    wait_done(200);
    spacing_chk = 0;
    repeat (3) tick();
    check("idle_after_done", BUSY, 0);

    // Tie on the minimum: lowest tap wins.
    err_tab[0] = 24'd9; err_tab[1] = 24'd3; err_tab[2] = 24'd3; err_tab[3] = 24'd7;
    start_sweep();
    wait_done(200);
    repeat (2) tick();

    // Backpressure during tap 2.
    rand_errs();
    start_sweep();
    wait_ld_tap(2, 100);
    OUT_READY = 1'b0;
    for (int i = 0; i < 40 && !OUT_VALID; i++) tick();
    check("bp_valid", OUT_VALID, 1);
    check("bp_tap", OUT_TAP, 2);
    repeat (10) tick();
    OUT_READY = 1'b1;
    wait_done(200);
    repeat (2) tick();

    // DLY_RDY drop mid-COUNT at tap 1: tap is redone in full.
    rand_errs();
    start_sweep();
    wait_ld_tap(1, 100);
    repeat (SETTLE + 6) tick();
    check("drop_in_count", CNT_EN, 1);
    DLY_RDY = 1'b0;
    tick();
    check("drop_wait_rdy", DBG_STATE, 1);
    repeat (4) tick();
    check("drop_no_en", CNT_EN, 0);
    DLY_RDY = 1'b1;
    wait_ld_tap(1, 10);
    wait_done(300);
    repeat (2) tick();

    // START while busy is ignored.
    rand_errs();
    d0 = done_cnt;
    start_sweep();
    wait_ld_tap(1, 100);
    START = 1'b1; tick(); START = 1'b0;
    wait_ld_tap(3, 100);
    START = 1'b1; tick(); START = 1'b0;
    wait_done(200);
    repeat (40) tick();
    check("busy_start_dones", done_cnt, d0 + 1);
    check("busy_start_idle", BUSY, 0);

    // Reset during SETTLE at tap 2, then a clean restart.
    rand_errs();
    start_sweep();
    wait_ld_tap(2, 100);
    tick();
    check("in_settle", DBG_STATE, 3);
    RST = 1'b0;
    tick();
    check("mid_rst_outs", {BUSY, DONE, DLY_LD, CNT_RST, CNT_EN, OUT_VALID, DLY_TAP, OUT_TAP, OUT_ERR, BEST_TAP}, 0);
    check("mid_rst_best_err", BEST_ERR, 24'hFFFFFF);
    RST = 1'b1;
    exp_q.delete();
    prev_valid = 0;
    d0 = done_cnt;
    repeat (30) tick();
    check("mid_rst_no_done", done_cnt, d0);
    rand_errs();
    start_sweep();
    wait_done(200);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
